// File: rtl/axi_inter_rr_arb.sv
// M-to-1 round-robin arbiter and pass-through mux for one AXI4 valid/ready channel.
// The grant is locked for one beat (LAST_LOCK=0) or until the beat flagged last (LAST_LOCK=1).
module axi_inter_rr_arb #(
   parameter int unsigned M         = 4,
   parameter int unsigned DW        = 64,
   parameter int unsigned LAST_LOCK = 0,
   localparam int unsigned IW       = (M > 1) ? $clog2(M) : 1
) (
   input  logic            clk,
   input  logic            rstn,
   input  logic [M-1:0]    s_valid,
   output logic [M-1:0]    s_ready,
   input  logic [M*DW-1:0] s_data,
   input  logic [M-1:0]    s_last,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_data,
   output logic            m_last,
   output logic [IW-1:0]   grant_id,
   output logic            grant_vld
);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e        state_q, state_d;
   logic [IW-1:0] grant_q, grant_d;
   logic [IW-1:0] ptr_q, ptr_d;

   logic [IW-1:0] winner;
   logic          found;
   logic [IW:0]   idx;
   logic          busy;
   logic          sel_valid;
   logic          sel_last;
   logic          hs;
   logic          rel;

   // Rotating-priority scan: ptr, ptr+1, ..., M-1, 0, ..., ptr-1.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < M; k++) begin
         idx = {1'b0, ptr_q} + (IW+1)'(k);
         if (idx >= (IW+1)'(M)) begin
            idx = idx - (IW+1)'(M);
         end
         if (!found && s_valid[idx[IW-1:0]]) begin
            found  = 1'b1;
            winner = idx[IW-1:0];
         end
      end
   end

   // Payload follows grant_q even in IDLE so m_data does not toggle between grants.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      m_data    = '0;
      for (int i = 0; i < M; i++) begin
         if (grant_q == IW'(i)) begin
            sel_valid = s_valid[i];
            sel_last  = s_last[i];
            m_data    = s_data[i*DW +: DW];
         end
      end
   end

   assign busy      = (state_q == StBusy);
   assign m_valid   = busy & sel_valid;
   assign m_last    = (LAST_LOCK != 0) ? sel_last : 1'b1;
   assign hs        = m_valid & m_ready;
   assign rel       = hs & ((LAST_LOCK == 0) | sel_last);
   assign grant_id  = grant_q;
   assign grant_vld = busy;

   always_comb begin
      s_ready = '0;
      for (int i = 0; i < M; i++) begin
         if (busy && (grant_q == IW'(i))) begin
            s_ready[i] = m_ready;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         StIdle: begin
            if (|s_valid) begin
               grant_d = winner;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (rel) begin
               state_d = StIdle;
               ptr_d   = (grant_q == IW'(M-1)) ? '0 : grant_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= StIdle;
         grant_q <= '0;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

endmodule

// File: tb/tb_axi_inter_rr_arb.sv
// Directed bench: one single-beat instance (u0) and one burst-lock instance (u1) on shared stimulus.
module tb_axi_inter_rr_arb;

   localparam int unsigned M  = 4;
   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rstn;
   logic [M-1:0]  s_valid;
   logic [M*DW-1:0] s_data;
   logic [M-1:0]  s_last;
   logic          m_ready;

   logic [M-1:0]  s_ready0, s_ready1;
   logic          m_valid0, m_valid1;
   logic [DW-1:0] m_data0, m_data1;
   logic          m_last0, m_last1;
   logic [1:0]    grant_id0, grant_id1;
   logic          grant_vld0, grant_vld1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   axi_inter_rr_arb #(.M(M), .DW(DW), .LAST_LOCK(0)) u0 (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready), .m_data(m_data0),
      .m_last(m_last0), .grant_id(grant_id0), .grant_vld(grant_vld0)
   );

   axi_inter_rr_arb #(.M(M), .DW(DW), .LAST_LOCK(1)) u1 (
      .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready1), .s_data(s_data),
      .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1),
      .m_last(m_last1), .grant_id(grant_id1), .grant_vld(grant_vld1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [3:0] exp_g;
      logic [DW-1:0] dvals [4];
      exp_g = '0;
      // Reset with requests present
      rstn    = 1'b0;
      s_valid = 4'b1011;
      s_data  = {8'h13, 8'hA5, 8'h11, 8'h10};
      s_last  = 4'b0010;
      m_ready = 1'b1;
      #3;
      chk("rst_s_ready0", 32'(s_ready0), 32'h0);
      chk("rst_m_valid0", 32'(m_valid0), 32'h0);
      chk("rst_grant_id0", 32'(grant_id0), 32'h0);
      chk("rst_grant_vld0", 32'(grant_vld0), 32'h0);
      chk("rst_m_last0", 32'(m_last0), 32'h1);
      chk("rst_m_data0", 32'(m_data0), 32'h10);
      chk("rst_s_ready1", 32'(s_ready1), 32'h0);
      chk("rst_m_last1", 32'(m_last1), 32'h0);
      next_cycle();
      next_cycle();

      // First grant to lowest active index, then backpressure on master 1
      s_valid = 4'b1010;
      m_ready = 1'b0;
      rstn    = 1'b1;
      @(negedge clk);
      chk("idle_m_valid0", 32'(m_valid0), 32'h0);
      next_cycle();
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_grant_id0", 32'(grant_id0), 32'h1);
         chk("bp_grant_vld0", 32'(grant_vld0), 32'h1);
         chk("bp_s_ready0", 32'(s_ready0), 32'h0);
         chk("bp_m_data0", 32'(m_data0), 32'h11);
         chk("bp_m_valid0", 32'(m_valid0), 32'h1);
         chk("bp_grant_id1", 32'(grant_id1), 32'h1);
         next_cycle();
      end
      m_ready = 1'b1;
      @(negedge clk);
      chk("bp_rel_s_ready0", 32'(s_ready0), 32'h2);
      chk("bp_rel_s_ready1", 32'(s_ready1), 32'h2);
      next_cycle();
      s_valid = 4'b0000;
      @(negedge clk);
      chk("bp_after_vld0", 32'(grant_vld0), 32'h0);
      chk("bp_after_vld1", 32'(grant_vld1), 32'h0);
      chk("idle_hold_m_data0", 32'(m_data0), 32'h11);
      chk("idle_s_ready0", 32'(s_ready0), 32'h0);

      // Single request from master 2
      next_cycle();
      s_valid = 4'b0100;
      next_cycle();
      @(negedge clk);
      chk("single_grant_id0", 32'(grant_id0), 32'h2);
      chk("single_m_data0", 32'(m_data0), 32'hA5);
      chk("single_s_ready0", 32'(s_ready0), 32'h4);
      chk("single_m_last0", 32'(m_last0), 32'h1);
      next_cycle();
      s_valid = 4'b1111;
      @(negedge clk);
      chk("single_release0", 32'(grant_vld0), 32'h0);

      // Fairness: ptr=3 after master 2, so order 3,0,1,2,3,0
      dvals[0] = 8'h10; dvals[1] = 8'h11; dvals[2] = 8'hA5; dvals[3] = 8'h13;
      for (int k = 0; k < 6; k++) begin
         exp_g = 4'((k + 3) % 4);
         next_cycle();
         @(negedge clk);
         chk("fair_grant_id0", 32'(grant_id0), 32'(exp_g));
         chk("fair_m_data0", 32'(m_data0), 32'(dvals[exp_g[1:0]]));
         chk("fair_s_ready0", 32'(s_ready0), 32'(4'b0001 << exp_g[1:0]));
         next_cycle();
         @(negedge clk);
         chk("fair_bubble0", 32'(grant_vld0), 32'h0);
      end

      // Burst lock on u1: master 1 sends 4 beats while master 3 waits
      rstn    = 1'b0;
      s_valid = 4'b0000;
      s_last  = 4'b0000;
      #2;
      rstn    = 1'b1;
      next_cycle();
      s_valid = 4'b1010;
      s_data[15:8] = 8'hB1;
      next_cycle();
      for (int b = 1; b <= 4; b++) begin
         s_data[15:8] = 8'(8'hB0 + b);
         s_last[1]    = (b == 4);
         @(negedge clk);
         chk("burst_grant_id1", 32'(grant_id1), 32'h1);
         chk("burst_s_ready1", 32'(s_ready1), 32'h2);
         chk("burst_m_data1", 32'(m_data1), 32'(8'hB0 + b));
         chk("burst_m_last1", 32'(m_last1), 32'(b == 4));
         next_cycle();
      end
      s_valid = 4'b1000;
      s_last  = 4'b0000;
      @(negedge clk);
      chk("burst_bubble1", 32'(grant_vld1), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("burst_next_grant1", 32'(grant_id1), 32'h3);
      chk("burst_next_vld1", 32'(grant_vld1), 32'h1);

      // Reset mid-burst after two beats from master 3
      next_cycle();
      next_cycle();
      #2;
      rstn = 1'b0;
      #1;
      chk("mid_rst_m_valid1", 32'(m_valid1), 32'h0);
      chk("mid_rst_s_ready1", 32'(s_ready1), 32'h0);
      chk("mid_rst_vld1", 32'(grant_vld1), 32'h0);
      chk("mid_rst_grant_id1", 32'(grant_id1), 32'h0);
      next_cycle();
      rstn    = 1'b1;
      s_valid = 4'b1010;
      next_cycle();
      @(negedge clk);
      chk("post_rst_grant1", 32'(grant_id1), 32'h1);
      chk("post_rst_grant0", 32'(grant_id0), 32'h1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
